// File: rtl/branch_pkg.sv
// Shared encodings, comparator controls, FSM states and target arithmetic for the
// branch resolution sequencer.
package branch_pkg;

   localparam logic [2:0] OP_BEQ  = 3'd0;
   localparam logic [2:0] OP_BNE  = 3'd1;
   localparam logic [2:0] OP_BGTZ = 3'd2;
   localparam logic [2:0] OP_BLEZ = 3'd3;
   localparam logic [2:0] OP_BLTZ = 3'd4;
   localparam logic [2:0] OP_BGEZ = 3'd5;

   localparam logic [1:0] CMP_NEZ = 2'd0;
   localparam logic [1:0] CMP_GTZ = 2'd1;
   localparam logic [1:0] CMP_LTZ = 2'd2;
   localparam logic [1:0] CMP_OFF = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StEval,
      StRedirect
   } br_state_e;

   // Only the two-register compares depend on rt.
   function automatic logic op_uses_rt(input logic [2:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic [31:0] br_target_calc(input logic [31:0] pc,
                                                  input logic [15:0] imm,
                                                  input logic        taken);
      logic [31:0] seq_pc;
      logic [31:0] offset;
      seq_pc = pc + 32'd4;
      offset = {{14{imm[15]}}, imm, 2'b00};
      return taken ? (seq_pc + offset) : seq_pc;
   endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Shared zero/sign comparator: tests a single operand against zero under a
// two-bit control code.
module branch_ctrl_cmp
   import branch_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [1:0]  ctrl_i,
   output logic        result_o
);

   always_comb begin
      result_o = 1'b0;
      case (ctrl_i)
         CMP_NEZ: result_o = (a_i != 32'd0);
         CMP_GTZ: result_o = !a_i[31] && (a_i != 32'd0);
         CMP_LTZ: result_o = a_i[31];
         default: result_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: accepts one branch, waits out operand hazards,
// resolves through the shared comparator and drives a multi-cycle front-end flush.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid_i,
   output logic             br_ready_o,
   input  logic [2:0]       br_op_i,
   input  logic [31:0]      br_pc_i,
   input  logic [15:0]      br_imm_i,
   input  logic [31:0]      rs_val_i,
   input  logic [31:0]      rt_val_i,
   input  logic             rs_busy_i,
   input  logic             rt_busy_i,
   input  logic             kill_i,
   output logic             resolve_valid_o,
   output logic             br_taken_o,
   output logic [31:0]      br_target_o,
   output logic             br_illegal_o,
   output logic             flush_o,
   output logic [CNT_W-1:0] taken_cnt_o,
   output logic [CNT_W-1:0] ntaken_cnt_o
);

   localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES - 1);

   br_state_e        state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      pc_q, pc_d;
   logic [15:0]      imm_q, imm_d;
   logic [31:0]      rs_q, rs_d;
   logic [31:0]      rt_q, rt_d;
   logic [FcW-1:0]   fcnt_q, fcnt_d;
   logic             resolve_valid_q, resolve_valid_d;
   logic             taken_q, taken_d;
   logic [31:0]      target_q, target_d;
   logic             illegal_q, illegal_d;
   logic             flush_q, flush_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

   logic [31:0] cmp_a;
   logic [1:0]  cmp_ctrl;
   logic        cmp_result;
   logic        eval_illegal;
   logic        eval_invert;
   logic        eval_taken;
   logic        idle_busy;
   logic        wait_busy;

   branch_ctrl_cmp u_cmp (
      .a_i      (cmp_a),
      .ctrl_i   (cmp_ctrl),
      .result_o (cmp_result)
   );

   // Comparator operand/control come only from the captured branch registers.
   always_comb begin
      cmp_a    = rs_q;
      cmp_ctrl = CMP_OFF;
      case (op_q)
         OP_BEQ, OP_BNE: begin
            cmp_a    = rs_q - rt_q;
            cmp_ctrl = CMP_NEZ;
         end
         OP_BGTZ, OP_BLEZ: cmp_ctrl = CMP_GTZ;
         OP_BLTZ, OP_BGEZ: cmp_ctrl = CMP_LTZ;
         default:          cmp_ctrl = CMP_OFF;
      endcase
   end

   assign eval_illegal = (op_q > OP_BGEZ);
   assign eval_invert  = (op_q == OP_BEQ) || (op_q == OP_BLEZ) || (op_q == OP_BGEZ);
   assign eval_taken   = !eval_illegal && (cmp_result ^ eval_invert);

   assign idle_busy = rs_busy_i || (op_uses_rt(br_op_i) && rt_busy_i);
   assign wait_busy = rs_busy_i || (op_uses_rt(op_q) && rt_busy_i);

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      pc_d            = pc_q;
      imm_d           = imm_q;
      rs_d            = rs_q;
      rt_d            = rt_q;
      fcnt_d          = fcnt_q;
      resolve_valid_d = 1'b0;
      taken_d         = taken_q;
      target_d        = target_q;
      illegal_d       = illegal_q;
      flush_d         = 1'b0;
      taken_cnt_d     = taken_cnt_q;
      ntaken_cnt_d    = ntaken_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (br_valid_i && !kill_i) begin
               op_d    = br_op_i;
               pc_d    = br_pc_i;
               imm_d   = br_imm_i;
               rs_d    = rs_val_i;
               rt_d    = rt_val_i;
               state_d = idle_busy ? StWait : StEval;
            end
         end
         StWait: begin
            if (kill_i) begin
               state_d = StIdle;
            end else begin
               // Keep tracking forwarded values; the clear cycle's copy is the one used.
               rs_d = rs_val_i;
               rt_d = rt_val_i;
               if (!wait_busy) begin
                  state_d = StEval;
               end
            end
         end
         StEval: begin
            if (kill_i) begin
               state_d = StIdle;
            end else begin
               resolve_valid_d = 1'b1;
               taken_d         = eval_taken;
               illegal_d       = eval_illegal;
               target_d        = br_target_calc(pc_q, imm_q, eval_taken);
               if (eval_taken) begin
                  if (taken_cnt_q != {CNT_W{1'b1}}) begin
                     taken_cnt_d = taken_cnt_q + CNT_W'(1);
                  end
                  flush_d = 1'b1;
                  fcnt_d  = FcLoad;
                  state_d = StRedirect;
               end else begin
                  if (ntaken_cnt_q != {CNT_W{1'b1}}) begin
                     ntaken_cnt_d = ntaken_cnt_q + CNT_W'(1);
                  end
                  state_d = StIdle;
               end
            end
         end
         StRedirect: begin
            if (kill_i || (fcnt_q == '0)) begin
               state_d = StIdle;
            end else begin
               fcnt_d  = fcnt_q - FcW'(1);
               flush_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         op_q            <= 3'd0;
         pc_q            <= 32'd0;
         imm_q           <= 16'd0;
         rs_q            <= 32'd0;
         rt_q            <= 32'd0;
         fcnt_q          <= '0;
         resolve_valid_q <= 1'b0;
         taken_q         <= 1'b0;
         target_q        <= 32'd0;
         illegal_q       <= 1'b0;
         flush_q         <= 1'b0;
         taken_cnt_q     <= '0;
         ntaken_cnt_q    <= '0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         pc_q            <= pc_d;
         imm_q           <= imm_d;
         rs_q            <= rs_d;
         rt_q            <= rt_d;
         fcnt_q          <= fcnt_d;
         resolve_valid_q <= resolve_valid_d;
         taken_q         <= taken_d;
         target_q        <= target_d;
         illegal_q       <= illegal_d;
         flush_q         <= flush_d;
         taken_cnt_q     <= taken_cnt_d;
         ntaken_cnt_q    <= ntaken_cnt_d;
      end
   end

   assign br_ready_o      = (state_q == StIdle);
   assign resolve_valid_o = resolve_valid_q;
   assign br_taken_o      = taken_q;
   assign br_target_o     = target_q;
   assign br_illegal_o    = illegal_q;
   assign flush_o         = flush_q;
   assign taken_cnt_o     = taken_cnt_q;
   assign ntaken_cnt_o    = ntaken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed and randomized branches checked against a
// behavioural outcome/latency/flush model.
module tb_branch_ctrl;

   localparam int FLUSH = 2;
   localparam int CW    = 2;
   localparam int SAT   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          br_valid;
   logic          br_ready;
   logic [2:0]    br_op;
   logic [31:0]   br_pc;
   logic [15:0]   br_imm;
   logic [31:0]   rs_val;
   logic [31:0]   rt_val;
   logic          rs_busy;
   logic          rt_busy;
   logic          kill;
   logic          resolve_valid;
   logic          br_taken;
   logic [31:0]   br_target;
   logic          br_illegal;
   logic          flush;
   logic [CW-1:0] taken_cnt;
   logic [CW-1:0] ntaken_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_tc   = 0;
   int exp_nc   = 0;

   always #5 clk = ~clk;

   branch_ctrl #(
      .FLUSH_CYCLES (FLUSH),
      .CNT_W        (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .br_valid_i      (br_valid),
      .br_ready_o      (br_ready),
      .br_op_i         (br_op),
      .br_pc_i         (br_pc),
      .br_imm_i        (br_imm),
      .rs_val_i        (rs_val),
      .rt_val_i        (rt_val),
      .rs_busy_i       (rs_busy),
      .rt_busy_i       (rt_busy),
      .kill_i          (kill),
      .resolve_valid_o (resolve_valid),
      .br_taken_o      (br_taken),
      .br_target_o     (br_target),
      .br_illegal_o    (br_illegal),
      .flush_o         (flush),
      .taken_cnt_o     (taken_cnt),
      .ntaken_cnt_o    (ntaken_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outcome straight from the ISA definition of each branch.
   function automatic void ref_branch(input logic [2:0] op, input logic [31:0] pc,
                                      input logic [15:0] imm, input logic [31:0] rs,
                                      input logic [31:0] rt, output bit taken,
                                      output bit illegal, output logic [31:0] target);
      int srs;
      srs     = rs;
      illegal = 1'b0;
      case (op)
         3'd0:    taken = (rs == rt);
         3'd1:    taken = (rs != rt);
         3'd2:    taken = (srs > 0);
         3'd3:    taken = (srs <= 0);
         3'd4:    taken = (srs < 0);
         3'd5:    taken = (srs >= 0);
         default: begin taken = 1'b0; illegal = 1'b1; end
      endcase
      target = pc + 32'd4;
      if (taken) target = target + 32'(int'($signed(imm)) * 4);
   endfunction

   task automatic bump(input bit taken);
      if (taken) exp_tc = (exp_tc < SAT) ? exp_tc + 1 : SAT;
      else       exp_nc = (exp_nc < SAT) ? exp_nc + 1 : SAT;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".ready"},   br_ready, 1);
      chk({tag, ".rv"},      resolve_valid, 0);
      chk({tag, ".taken"},   br_taken, 0);
      chk({tag, ".target"},  br_target, 0);
      chk({tag, ".illegal"}, br_illegal, 0);
      chk({tag, ".flush"},   flush, 0);
      chk({tag, ".tcnt"},    taken_cnt, 0);
      chk({tag, ".ncnt"},    ntaken_cnt, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_tc = 0;
      exp_nc = 0;
   endtask

   // Cycle c relative to accept: busy bits high while c < nbusy; the specified
   // operands appear only in cycle 'keep', everything else is noise.
   task automatic drive_ops(input int c, input int keep, input int nbusy, input bit brs,
                            input bit brt, input logic [31:0] rs, input logic [31:0] rt);
      rs_busy = brs && (c < nbusy);
      rt_busy = brt && (c < nbusy);
      rs_val  = (c == keep) ? rs : $urandom;
      rt_val  = (c == keep) ? rt : $urandom;
   endtask

   task automatic run_branch(input string tag, input logic [2:0] op, input logic [31:0] pc,
                             input logic [15:0] imm, input logic [31:0] rs,
                             input logic [31:0] rt, input int nbusy, input bit brs,
                             input bit brt);
      bit          taken;
      bit          illegal;
      logic [31:0] target;
      int          keep;
      int          lat;
      int          fl;
      keep = ((brs || (brt && op <= 3'd1)) && nbusy > 0) ? nbusy : 0;
      ref_branch(op, pc, imm, rs, rt, taken, illegal, target);
      @(negedge clk);
      chk({tag, ".ready_in"}, br_ready, 1);
      br_valid = 1'b1;
      br_op    = op;
      br_pc    = pc;
      br_imm   = imm;
      drive_ops(0, keep, nbusy, brs, brt, rs, rt);
      lat = -1;
      for (int c = 1; c <= keep + 8 && lat < 0; c++) begin
         @(negedge clk);
         br_valid = 1'b0;
         br_op    = 3'($urandom);
         br_pc    = $urandom;
         br_imm   = 16'($urandom);
         if (resolve_valid === 1'b1) lat = c;
         drive_ops(c, keep, nbusy, brs, brt, rs, rt);
      end
      chk({tag, ".latency"}, lat, keep + 2);
      chk({tag, ".taken"},   br_taken, taken);
      chk({tag, ".target"},  br_target, target);
      chk({tag, ".illegal"}, br_illegal, illegal);
      bump(taken);
      chk({tag, ".tcnt"}, taken_cnt, exp_tc);
      chk({tag, ".ncnt"}, ntaken_cnt, exp_nc);
      fl = 0;
      for (int c = 0; c < FLUSH + 4 && flush === 1'b1; c++) begin
         fl++;
         chk({tag, ".ready_fl"}, br_ready, 0);
         @(negedge clk);
         chk({tag, ".rv_pulse"}, resolve_valid, 0);
      end
      chk({tag, ".flush_len"}, fl, taken ? FLUSH : 0);
      if (!taken) @(negedge clk);
      chk({tag, ".ready_out"}, br_ready, 1);
      rs_busy = 1'b0;
      rt_busy = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      br_valid = 1'b0;
      br_op    = 3'd0;
      br_pc    = 32'd0;
      br_imm   = 16'd0;
      rs_val   = 32'd0;
      rt_val   = 32'd0;
      rs_busy  = 1'b0;
      rt_busy  = 1'b0;
      kill     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reset_state("por");

      // Directed outcomes, including target wrap-around.
      run_branch("beq_taken", 3'd0, 32'h0040_0000, 16'h0004, 32'h1234, 32'h1234, 0, 0, 0);
      run_branch("bne_eq",    3'd1, 32'h0040_0100, 16'h0010, 32'd5, 32'd5, 0, 0, 0);
      run_branch("bgtz_0",    3'd2, 32'h1000_0000, 16'h0020, 32'd0, 32'd9, 0, 0, 0);
      run_branch("blez_0",    3'd3, 32'h0000_0000, 16'hFFFF, 32'd0, 32'd9, 0, 0, 0);
      run_branch("bltz_min",  3'd4, 32'h2000_0000, 16'h8000, 32'h8000_0000, 32'd0, 0, 0, 0);
      run_branch("bgez_min",  3'd5, 32'h2000_0000, 16'h0100, 32'h8000_0000, 32'd0, 0, 0, 0);
      run_branch("bne_ne",    3'd1, 32'hFFFF_FFF0, 16'h0008, 32'd5, 32'd6, 0, 0, 0);

      // Hazards: needed and ignored busy bits.
      run_branch("beq_rthaz", 3'd0, 32'h0040_2000, 16'h0003, 32'h77, 32'h77, 3, 0, 1);
      run_branch("bgtz_rt",   3'd2, 32'h0040_3000, 16'h0003, 32'd5, 32'd0, 3, 0, 1);
      run_branch("bltz_rs",   3'd4, 32'h0040_4000, 16'hFFF0, 32'hFFFF_FFFF, 32'd0, 2, 1, 0);

      // kill during EVAL drops the resolve.
      pulse_reset();
      @(negedge clk);
      br_valid = 1'b1; br_op = 3'd0; br_pc = 32'h0050_0000; br_imm = 16'h0001;
      rs_val = 32'd3; rt_val = 32'd3;
      @(negedge clk);
      br_valid = 1'b0;
      kill     = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_eval.rv",    resolve_valid, 0);
      chk("kill_eval.flush", flush, 0);
      chk("kill_eval.ready", br_ready, 1);
      chk("kill_eval.tcnt",  taken_cnt, exp_tc);
      chk("kill_eval.ncnt",  ntaken_cnt, exp_nc);

      // kill in the first REDIRECT cycle cuts the flush short.
      br_valid = 1'b1;
      @(negedge clk);
      br_valid = 1'b0;
      @(negedge clk);
      kill = 1'b1;
      chk("kill_red.rv",    resolve_valid, 1);
      chk("kill_red.flush", flush, 1);
      bump(1'b1);
      @(negedge clk);
      kill = 1'b0;
      chk("kill_red.flush_off", flush, 0);
      chk("kill_red.rv_off",    resolve_valid, 0);
      chk("kill_red.ready",     br_ready, 1);
      chk("kill_red.tcnt",      taken_cnt, exp_tc);
      chk("kill_red.ncnt",      ntaken_cnt, exp_nc);

      // kill in IDLE blocks acceptance.
      br_valid = 1'b1;
      kill     = 1'b1;
      @(negedge clk);
      br_valid = 1'b0;
      kill     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("kill_idle.ready", br_ready, 1);
         chk("kill_idle.rv",    resolve_valid, 0);
         @(negedge clk);
      end

      // Saturation and illegal ops.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         run_branch("sat_taken", 3'd0, $urandom, 16'($urandom), 32'd8, 32'd8, 0, 0, 0);
      end
      chk("sat.tcnt_max", taken_cnt, 3);
      run_branch("illegal7", 3'd7, 32'h0060_0000, 16'h0040, 32'd1, 32'd1, 0, 0, 0);
      run_branch("illegal6", 3'd6, 32'h0060_0100, 16'h0040, 32'd0, 32'd0, 0, 0, 0);

      // Randomized branches against the model.
      pulse_reset();
      for (int i = 0; i < 48; i++) begin
         logic [31:0] rs;
         logic [31:0] rt;
         case ($urandom_range(0, 5))
            0:       rs = 32'd0;
            1:       rs = 32'd1;
            2:       rs = 32'h8000_0000;
            3:       rs = 32'h7FFF_FFFF;
            4:       rs = 32'hFFFF_FFFF;
            default: rs = $urandom;
         endcase
         rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
         run_branch("rand", 3'($urandom_range(0, 7)), $urandom, 16'($urandom), rs, rt,
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         if (i % 12 == 11) pulse_reset();
      end

      // Reset in the middle of a hazard wait.
      @(negedge clk);
      br_valid = 1'b1; br_op = 3'd2; br_pc = 32'h0070_0000; br_imm = 16'h0004;
      rs_val = 32'd4; rs_busy = 1'b1;
      @(negedge clk);
      br_valid = 1'b0;
      chk("rst_wait.in_wait", br_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      rs_busy = 1'b0;
      exp_tc  = 0;
      exp_nc  = 0;
      check_reset_state("rst_wait");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_wait.no_rv", resolve_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution sequencer for the 32-bit MIPS-style pipeline.
- Accepts one branch at a time from decode and waits out operand hazards reported by the scoreboard.
- Drives the shared zero/sign comparator with the operand and control code, then reports taken/not-taken, the target PC and a multi-cycle front-end flush.
- Keeps saturating taken/not-taken statistics counters.

Parameters:
- FLUSH_CYCLES, 2: cycles `flush` is held high after a taken branch, including the resolve cycle; legal range ≥1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- br_valid  in  1  decode presents a branch
- br_ready  out  1  controller can accept a branch
- br_op  in  3  0 BEQ, 1 BNE, 2 BGTZ, 3 BLEZ, 4 BLTZ, 5 BGEZ, 6–7 illegal
- br_pc  in  32  PC of the branch instruction
- br_imm  in  16  signed word offset
- rs_val  in  32  forwarded rs value
- rt_val  in  32  forwarded rt value
- rs_busy  in  1  rs not yet available
- rt_busy  in  1  rt not yet available
- kill  in  1  pipeline exception; aborts any branch in flight
- resolve_valid  out  1  one-cycle pulse when a branch resolves
- br_taken  out  1  outcome, valid while resolve_valid is high
- br_target  out  32  next PC, valid while resolve_valid is high
- br_illegal  out  1  op was 6 or 7, valid while resolve_valid is high
- flush  out  1  squash wrong-path fetch
- taken_cnt  out  CNT_W  branches resolved taken (saturating)
- ntaken_cnt  out  CNT_W  branches resolved not-taken (saturating)

Behaviour:
- **Reset.** Ports: `clk`; reset is synchronous and active-high, named `reset`. At reset: state IDLE; all outputs 0 except `br_ready`=1; both counters 0.
- **States.** IDLE, WAIT, EVAL, REDIRECT.
- **IDLE.**
  - `br_ready`=1. Accept occurs when `br_valid`=1 and `kill`=0.
  - On accept, capture op, pc, imm, rs_val and rt_val.
  - Next state is WAIT if the needed busy bit is set, otherwise EVAL.
  - rt is needed only for BEQ/BNE; for other ops `rt_busy` is ignored.
- **WAIT.**
  - `br_ready`=0. Re-capture rs_val/rt_val every cycle.
  - Go to EVAL in the first cycle the needed busy bits are all 0; that cycle's values are the ones kept.
- **EVAL.** Comparator is driven from the captured registers:
  - BEQ/BNE: a = rs − rt (mod 2^32), control 0 (a≠0).
  - BGTZ/BLEZ: a = rs, control 1 (a>0 signed).
  - BLTZ/BGEZ: a = rs, control 2 (a<0 signed).
  - Decision: BNE, BGTZ, BLTZ take the comparator result; BEQ, BLEZ, BGEZ take its inverse.
  - Illegal op: control 3, taken=0, illegal=1.
- **EVAL edge.** Register the following, then go to REDIRECT if taken, else IDLE:
  - `resolve_valid`=1 for exactly one cycle.
  - `br_taken` and `br_illegal`.
  - `br_target`: taken → pc + 4 + (sext(imm) << 2); not-taken or illegal → pc + 4. 32-bit, wraps mod 2^32.
  - If taken, `flush`=1 and the flush counter is loaded with FLUSH_CYCLES−1.
- **REDIRECT.**
  - `br_ready`=0, `flush`=1. Decrement each cycle; leave for IDLE when the count reaches 0.
  - `flush` drops in the first IDLE cycle.
  - With FLUSH_CYCLES=1, REDIRECT lasts one cycle.
- **Latency.**
  - Hazard-free: accept at edge N → `resolve_valid` high in cycle N+2 (the cycle after EVAL).
  - Each WAIT cycle adds 1.
  - Next accept is possible the cycle after resolve for not-taken, or after the flush completes for taken.
- **Counters.** Increment on the `resolve_valid` cycle; illegal ops count as not-taken. Saturate at 2^CNT_W−1; no wrap.
- **kill.**
  - In WAIT, EVAL or REDIRECT: next state IDLE; `flush` and `resolve_valid` forced 0 next cycle; counters unchanged; a pending resolve is dropped.
  - In IDLE: blocks acceptance.
- **Priority.** reset > kill > normal operation. Reset mid-operation behaves identically to power-on reset.
- **Registered outputs.** `resolve_valid`, `br_taken`, `br_target`, `br_illegal` and `flush` are registered. `br_ready` is decoded from state.

Decomposition:
- **Package `branch_pkg`:**
  - br_op encodings.
  - Comparator control constants: CMP_NEZ=0, CMP_GTZ=1, CMP_LTZ=2, CMP_OFF=3.
  - State enum.
  - Helper function for target computation.
- **Sub-module:** one instance of the existing comparator (a[31:0], control[1:0], result). No other sub-modules.

Test Plan:
- BEQ, rs=rt=0x1234, pc=0x00400000, imm=0x0004, no hazards → `resolve_valid` 2 cycles after accept, taken=1, target=0x00400014, `flush` high 2 cycles, taken_cnt=1.
- BNE, rs=5, rt=5 → taken=0, target=pc+4, no flush, ntaken_cnt=1, `br_ready` high the next cycle.
- BGTZ rs=0 → not taken; BLEZ rs=0 → taken; BLTZ rs=0x80000000 → taken; BGEZ rs=0x80000000 → not taken; imm=0xFFFF, pc=0x00000000 → target=0x00000000 (wrap check).
- BEQ with `rt_busy` high 3 cycles and rt_val changing each cycle → 3 WAIT cycles, decision uses the value present when busy drops, resolve 5 cycles after accept; BGTZ with only `rt_busy` high → no WAIT.
- `kill` in EVAL, and separately in the 1st REDIRECT cycle → no `resolve_valid` (or `flush` drops next cycle), state IDLE, counters unchanged; `reset` asserted mid-WAIT → all outputs at reset values.
- CNT_W=2, four taken branches → taken_cnt saturates at 3; op=7 → illegal=1, taken=0, ntaken_cnt increments.
